// File: rtl/debug_slave_cmd_bridge.sv
// debug_slave_cmd_bridge
// System-clock side of the debug slave command path. Update-IR / update-DR
// levels coming from the TCK domain are resynchronised and edge-detected.
// Each update-DR edge captures the scan register and hands the command to a
// one-deep valid/ready holding stage addressed by the captured instruction.
// Accepting a held command produces a one-cycle take_action or
// take_no_action pulse on the channel's bit. Dropped commands and commands
// for nonexistent channels are counted in saturating counters.
//
// Ports
//   clk, reset_n          system clock, async active-low reset
//   vs_uir, vs_udr        update-IR / update-DR levels (async to clk)
//   ir_in, sr             instruction and scan data (quasi-static)
//   cmd_ready, cnt_clr    consumer handshake, counter clear
//   jdo, ir_q             last captured scan data / instruction
//   cmd_valid/ch/data     holding stage
//   take_action/_no_action per-channel accept pulses
//   ovr_cnt, err_cnt      overrun / bad-instruction counters
module debug_slave_cmd_bridge #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACT_BIT     = 34,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vs_uir,
    input  logic              vs_udr,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [DATA_W-1:0] sr,
    input  logic              cmd_ready,
    input  logic              cnt_clr,
    output logic [DATA_W-1:0] jdo,
    output logic [IR_W-1:0]   ir_q,
    output logic              cmd_valid,
    output logic [IR_W-1:0]   cmd_ch,
    output logic [DATA_W-1:0] cmd_data,
    output logic [NUM_CH-1:0] take_action,
    output logic [NUM_CH-1:0] take_no_action,
    output logic [CNT_W-1:0]  ovr_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int            WARM_LIM = SYNC_STAGES + 1;
    localparam int            WARM_W   = $clog2(WARM_LIM + 1);
    localparam logic [IR_W:0] NUM_CH_L = (IR_W+1)'(NUM_CH);

    logic [SYNC_STAGES-1:0] r_uir_sync, r_udr_sync;
    logic                   r_uir_dly, r_udr_dly;
    logic                   r_uir_edge, r_udr_edge;
    logic [WARM_W-1:0]      r_warm;
    logic [DATA_W-1:0]      r_jdo, r_cmd_data;
    logic [IR_W-1:0]        r_ir_q, r_cmd_ch;
    logic                   r_cmd_valid;
    logic [NUM_CH-1:0]      r_take_act, r_take_noact;
    logic [CNT_W-1:0]       r_ovr_cnt, r_err_cnt;

    logic                   w_warm_done;
    logic [IR_W-1:0]        w_udr_ch;
    logic                   w_ch_ok;
    logic                   w_load, w_drop, w_bad, w_accept;
    logic [NUM_CH-1:0]      w_ch_oh;

    assign w_warm_done = (r_warm == WARM_W'(WARM_LIM));

    // An update-IR edge in the same cycle as update-DR already selects the
    // new channel, so the command is not routed with the stale instruction.
    assign w_udr_ch = r_uir_edge ? ir_in : r_ir_q;
    assign w_ch_ok  = ({1'b0, w_udr_ch} < NUM_CH_L);
    assign w_accept = r_cmd_valid & cmd_ready;
    assign w_load   = r_udr_edge & w_ch_ok & (~r_cmd_valid | cmd_ready);
    assign w_drop   = r_udr_edge & w_ch_ok & r_cmd_valid & ~cmd_ready;
    assign w_bad    = r_udr_edge & ~w_ch_ok;

    always_comb begin
        w_ch_oh = '0;
        for (int i = 0; i < NUM_CH; i++)
            w_ch_oh[i] = (r_cmd_ch == IR_W'(i));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_uir_sync   <= '0;
            r_udr_sync   <= '0;
            r_uir_dly    <= 1'b0;
            r_udr_dly    <= 1'b0;
            r_uir_edge   <= 1'b0;
            r_udr_edge   <= 1'b0;
            r_warm       <= '0;
            r_jdo        <= '0;
            r_ir_q       <= '0;
            r_cmd_valid  <= 1'b0;
            r_cmd_ch     <= '0;
            r_cmd_data   <= '0;
            r_take_act   <= '0;
            r_take_noact <= '0;
            r_ovr_cnt    <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
            r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
            // Delay flops track the synchronisers during warm-up, so a level
            // already high at reset release never looks like a rising edge.
            r_uir_dly  <= r_uir_sync[SYNC_STAGES-1];
            r_udr_dly  <= r_udr_sync[SYNC_STAGES-1];
            r_uir_edge <= w_warm_done & r_uir_sync[SYNC_STAGES-1] & ~r_uir_dly;
            r_udr_edge <= w_warm_done & r_udr_sync[SYNC_STAGES-1] & ~r_udr_dly;
            if (!w_warm_done)
                r_warm <= r_warm + 1'b1;

            if (r_uir_edge)
                r_ir_q <= ir_in;
            if (r_udr_edge)
                r_jdo <= sr;

            if (w_load) begin
                r_cmd_ch    <= w_udr_ch;
                r_cmd_data  <= sr;
                r_cmd_valid <= 1'b1;
            end else if (w_accept) begin
                r_cmd_valid <= 1'b0;
            end

            r_take_act   <= (w_accept &  r_cmd_data[ACT_BIT]) ? w_ch_oh : '0;
            r_take_noact <= (w_accept & ~r_cmd_data[ACT_BIT]) ? w_ch_oh : '0;

            if (cnt_clr)
                r_ovr_cnt <= '0;
            else if (w_drop && r_ovr_cnt != '1)
                r_ovr_cnt <= r_ovr_cnt + 1'b1;

            if (cnt_clr)
                r_err_cnt <= '0;
            else if (w_bad && r_err_cnt != '1)
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign jdo            = r_jdo;
    assign ir_q           = r_ir_q;
    assign cmd_valid      = r_cmd_valid;
    assign cmd_ch         = r_cmd_ch;
    assign cmd_data       = r_cmd_data;
    assign take_action    = r_take_act;
    assign take_no_action = r_take_noact;
    assign ovr_cnt        = r_ovr_cnt;
    assign err_cnt        = r_err_cnt;

endmodule

// File: tb/tb_debug_slave_cmd_bridge.sv
module tb_debug_slave_cmd_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vs_uir, vs_udr, cmd_ready, cnt_clr;
    logic [1:0]  ir_in;
    logic [37:0] sr;

    logic [37:0] jdo, cmd_data;
    logic [1:0]  ir_q, cmd_ch;
    logic        cmd_valid;
    logic [3:0]  take_action, take_no_action;
    logic [7:0]  ovr_cnt, err_cnt;

    logic [37:0] jdo3, cmd_data3;
    logic [1:0]  ir_q3, cmd_ch3;
    logic        cmd_valid3;
    logic [2:0]  take_action3, take_no_action3;
    logic [7:0]  ovr_cnt3, err_cnt3;

    int errors = 0;
    int checks = 0;
    logic [3:0] acc_act, acc_noact;
    int         pulse_cycles;

    always #5 clk = ~clk;

    debug_slave_cmd_bridge u_dut (
        .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr),
        .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .cnt_clr(cnt_clr),
        .jdo(jdo), .ir_q(ir_q), .cmd_valid(cmd_valid), .cmd_ch(cmd_ch),
        .cmd_data(cmd_data), .take_action(take_action),
        .take_no_action(take_no_action), .ovr_cnt(ovr_cnt), .err_cnt(err_cnt)
    );

    // Three-channel instance: instruction value 3 has no channel.
    debug_slave_cmd_bridge #(.NUM_CH(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr),
        .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .cnt_clr(cnt_clr),
        .jdo(jdo3), .ir_q(ir_q3), .cmd_valid(cmd_valid3), .cmd_ch(cmd_ch3),
        .cmd_data(cmd_data3), .take_action(take_action3),
        .take_no_action(take_no_action3), .ovr_cnt(ovr_cnt3), .err_cnt(err_cnt3)
    );

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] sr;
        logic [3:0]  exp_act;
        logic [3:0]  exp_noact;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n cycles, sampling pulse outputs at each falling edge.
    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            acc_act   |= take_action;
            acc_noact |= take_no_action;
            if (|take_action || |take_no_action) pulse_cycles++;
        end
    endtask

    task automatic clr_acc();
        acc_act = '0; acc_noact = '0; pulse_cycles = 0;
    endtask

    task automatic pulse(input logic u, input logic d);
        run(1);
        vs_uir = u; vs_udr = d;
        run(2);
        vs_uir = 1'b0; vs_udr = 1'b0;
        run(2);
    endtask

    initial begin
        vecs[0] = '{2'd1, 38'h04_0000_0055, 4'b0010, 4'b0000};
        vecs[1] = '{2'd3, 38'h00_0000_00AA, 4'b0000, 4'b1000};
        vecs[2] = '{2'd0, 38'h3F_FFFF_FFFF, 4'b0001, 4'b0000};
        vecs[3] = '{2'd2, 38'h3B_FFFF_FFFF, 4'b0000, 4'b0100};

        reset_n = 1'b0; vs_uir = 1'b0; vs_udr = 1'b0; cmd_ready = 1'b0;
        cnt_clr = 1'b0; ir_in = '0; sr = '0;
        clr_acc();
        run(3);
        chk("rst_jdo", 64'(jdo), 64'h0);
        chk("rst_ir_q", 64'(ir_q), 64'h0);
        chk("rst_cmd_valid", 64'(cmd_valid), 64'h0);
        chk("rst_take", 64'({take_action, take_no_action}), 64'h0);
        chk("rst_cnts", 64'({ovr_cnt, err_cnt}), 64'h0);
        reset_n = 1'b1;
        run(4);

        // Latency: vs_udr rises before edge 0, command held after edge 3.
        sr = 38'h00_0000_0011;
        vs_udr = 1'b1;
        run(3);            // negedges after edges 0,1,2
        vs_udr = 1'b0;
        chk("lat_not_yet", 64'(cmd_valid), 64'h0);
        run(1);            // after edge 3
        chk("lat_valid", 64'(cmd_valid), 64'h1);
        chk("lat_jdo", 64'(jdo), 64'h11);
        cmd_ready = 1'b1;
        run(4);
        chk("lat_drained", 64'(cmd_valid), 64'h0);

        foreach (vecs[i]) begin
            clr_acc();
            ir_in = vecs[i].ir;
            pulse(1'b1, 1'b0);
            sr = vecs[i].sr;
            pulse(1'b0, 1'b1);
            run(4);
            chk($sformatf("v%0d_ir_q", i), 64'(ir_q), 64'(vecs[i].ir));
            chk($sformatf("v%0d_jdo", i), 64'(jdo), 64'(vecs[i].sr));
            chk($sformatf("v%0d_cmd_data", i), 64'(cmd_data), 64'(vecs[i].sr));
            chk($sformatf("v%0d_act", i), 64'(acc_act), 64'(vecs[i].exp_act));
            chk($sformatf("v%0d_noact", i), 64'(acc_noact), 64'(vecs[i].exp_noact));
            chk($sformatf("v%0d_pulses", i), 64'(pulse_cycles), 64'h1);
            chk($sformatf("v%0d_valid", i), 64'(cmd_valid), 64'h0);
        end
        chk("vec_cnts", 64'({ovr_cnt, err_cnt}), 64'h0);

        // Overrun: first command held, next two dropped.
        cmd_ready = 1'b0; ir_in = 2'd0;
        pulse(1'b1, 1'b0);
        sr = 38'h1; pulse(1'b0, 1'b1);
        sr = 38'h2; pulse(1'b0, 1'b1);
        sr = 38'h3; pulse(1'b0, 1'b1);
        run(2);
        chk("ovr_valid", 64'(cmd_valid), 64'h1);
        chk("ovr_data", 64'(cmd_data), 64'h1);
        chk("ovr_cnt", 64'(ovr_cnt), 64'h2);
        chk("ovr_jdo", 64'(jdo), 64'h3);
        clr_acc();
        cmd_ready = 1'b1;
        run(4);
        chk("ovr_noact", 64'(acc_noact), 64'h1);
        chk("ovr_act", 64'(acc_act), 64'h0);
        chk("ovr_pulses", 64'(pulse_cycles), 64'h1);

        // Bad instruction on the three-channel instance.
        cnt_clr = 1'b1; run(1); cnt_clr = 1'b0;
        ir_in = 2'd3;
        pulse(1'b1, 1'b0);
        sr = 38'h55;
        pulse(1'b0, 1'b1);
        run(2);
        chk("bad_err1", 64'(err_cnt3), 64'h1);
        chk("bad_jdo", 64'(jdo3), 64'h55);
        chk("bad_valid", 64'(cmd_valid3), 64'h0);
        chk("good_err0", 64'(err_cnt), 64'h0);
        for (int n = 0; n < 299; n++) pulse(1'b0, 1'b1);
        run(2);
        chk("bad_sat", 64'(err_cnt3), 64'hFF);
        chk("bad_ovr0", 64'(ovr_cnt), 64'h0);
        cnt_clr = 1'b1; run(1); cnt_clr = 1'b0;
        chk("bad_clr", 64'(err_cnt3), 64'h0);

        // Same-cycle update-IR and update-DR routes to the new instruction.
        cmd_ready = 1'b0; ir_in = 2'd2; sr = 38'h22;
        pulse(1'b1, 1'b1);
        run(1);
        chk("sim_valid", 64'(cmd_valid), 64'h1);
        chk("sim_ch", 64'(cmd_ch), 64'h2);
        chk("sim_ir_q", 64'(ir_q), 64'h2);
        clr_acc();
        cmd_ready = 1'b1;
        run(3);
        chk("sim_noact", 64'(acc_noact), 64'b0100);

        // Level already high at reset release is not an edge.
        vs_udr = 1'b1; sr = 38'h77;
        reset_n = 1'b0; run(2); reset_n = 1'b1;
        run(8);
        chk("warm_valid", 64'(cmd_valid), 64'h0);
        chk("warm_jdo", 64'(jdo), 64'h0);
        vs_udr = 1'b0;
        run(2);
        cmd_ready = 1'b0;
        sr = 38'h5; pulse(1'b0, 1'b1);
        sr = 38'h6; pulse(1'b0, 1'b1);
        run(1);
        chk("mid_valid_pre", 64'(cmd_valid), 64'h1);
        chk("mid_ovr_pre", 64'(ovr_cnt), 64'h1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_valid_rst", 64'(cmd_valid), 64'h0);
        chk("mid_cnt_rst", 64'({ovr_cnt, err_cnt}), 64'h0);
        chk("mid_data_rst", 64'(cmd_data), 64'h0);
        run(2);
        reset_n = 1'b1;
        run(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
